// File: rtl/uart_line_pkg.sv
// uart_line_pkg: state encoding, terminator default and strobe gap lengths for uart_line_ctl
package uart_line_pkg;
    typedef enum logic [3:0] {
        IDLE, FLUSH, FLUSH_GAP, TX_CHK, TX_PULSE, TX_GAP, RX_WAIT, RX_POP, RX_GAP, DONE
    } state_t;
    localparam logic [7:0] TERM_DEF   = 8'h3E;
    localparam int         TX_GAP_CYC = 2;
    localparam int         RX_GAP_CYC = 2;
endpackage

// File: rtl/uart_line_buf.sv
// uart_line_buf: single-clock dual-port RAM, one write port and one registered read port
module uart_line_buf #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;
    // storage array, written synchronously
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    // registered read, cleared on reset so the output starts at zero
    always_ff @(posedge clk or posedge reset)
        if (reset) r_rdata <= '0;
        else r_rdata <= r_mem[i_raddr];
    assign o_rdata = r_rdata;
endmodule

// File: rtl/uart_line_ctl.sv
// uart_line_ctl: one command/response transaction over a uart per start edge; UART_LINE_ECHO_EN drops the device echo
module uart_line_ctl
    import uart_line_pkg::*;
#(
    parameter int              DBIT    = 8,
    parameter int              CMD_AW  = 4,
    parameter int              RSP_AW  = 5,
    parameter int              TO_BITS = 24,
    parameter logic [DBIT-1:0] TERM    = TERM_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [CMD_AW:0]    i_cmd_len,
    input  logic               i_cmd_wr,
    input  logic [CMD_AW-1:0]  i_cmd_addr,
    input  logic [DBIT-1:0]    i_cmd_wdata,
    input  logic [TO_BITS-1:0] i_timeout,
    input  logic [RSP_AW-1:0]  i_rsp_addr,
    output logic [DBIT-1:0]    o_rsp_rdata,
    output logic [RSP_AW:0]    o_rsp_len,
    output logic               o_busy,
    output logic               o_done_tick,
    output logic               o_e_timeout,
    output logic               o_e_rsp_of,
    output logic               o_uart_wr,
    output logic [DBIT-1:0]    o_uart_w_data,
    input  logic               i_uart_tx_full,
    output logic               o_uart_rd,
    input  logic [DBIT-1:0]    i_uart_r_data,
    input  logic               i_uart_rx_empty
);
    state_t             r_state, w_next;
    logic               r_start_d, w_start_edge, w_skip, w_rsp_we;
    logic [CMD_AW:0]    r_cmd_len, r_idx;
    logic [TO_BITS-1:0] r_timeout, r_to;
    logic [1:0]         r_gap;
    logic [DBIT-1:0]    r_byte, r_w_data, w_cmd_rdata;
    logic [RSP_AW:0]    r_rsp_len;
    logic               r_e_to, r_e_of, r_term;

    assign w_start_edge  = i_start && !r_start_d;
    assign o_rsp_len     = r_rsp_len;
    assign o_e_timeout   = r_e_to;
    assign o_e_rsp_of    = r_e_of;
    assign o_uart_w_data = r_w_data;

    uart_line_buf #(.DW(DBIT), .AW(CMD_AW)) u_cmd_buf (
        .clk(clk), .reset(reset), .i_we(i_cmd_wr && !o_busy), .i_waddr(i_cmd_addr),
        .i_wdata(i_cmd_wdata), .i_raddr(r_idx[CMD_AW-1:0]), .o_rdata(w_cmd_rdata)
    );

    uart_line_buf #(.DW(DBIT), .AW(RSP_AW)) u_rsp_buf (
        .clk(clk), .reset(reset), .i_we(w_rsp_we), .i_waddr(r_rsp_len[RSP_AW-1:0]),
        .i_wdata(r_byte), .i_raddr(i_rsp_addr), .o_rdata(o_rsp_rdata)
    );

`ifdef UART_LINE_ECHO_EN
    logic [CMD_AW:0] r_echo;
    // bytes of device echo still to be discarded before the real reply
    always_ff @(posedge clk or posedge reset)
        if (reset) r_echo <= '0;
        else if (r_state == IDLE && w_start_edge) r_echo <= i_cmd_len;
        else if (r_state == RX_POP && w_skip) r_echo <= r_echo - 1'b1;
    assign w_skip = (r_echo != '0);
`else
    assign w_skip = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else r_state <= w_next;

    // next state and strobes decoded from the current state
    always_comb begin
        w_next      = r_state;
        o_busy      = !(r_state == IDLE || r_state == DONE);
        o_done_tick = (r_state == DONE);
        o_uart_wr   = (r_state == TX_PULSE);
        o_uart_rd   = (r_state == RX_POP) || (r_state == FLUSH_GAP && r_gap == 2'(RX_GAP_CYC));
        w_rsp_we    = (r_state == RX_POP) && !w_skip && !r_rsp_len[RSP_AW];
        case (r_state)
            IDLE:      w_next = w_start_edge ? FLUSH : IDLE;
            FLUSH:     w_next = i_uart_rx_empty ? TX_CHK : FLUSH_GAP;
            FLUSH_GAP: w_next = (r_gap == 2'd0) ? FLUSH : FLUSH_GAP;
            TX_CHK:    w_next = (r_idx == r_cmd_len) ? RX_WAIT : i_uart_tx_full ? TX_CHK : TX_PULSE;
            TX_PULSE:  w_next = TX_GAP;
            TX_GAP:    w_next = (r_gap == 2'd0) ? TX_CHK : TX_GAP;
            RX_WAIT:   w_next = !i_uart_rx_empty ? RX_POP : (r_to == '0) ? DONE : RX_WAIT;
            RX_POP:    w_next = RX_GAP;
            RX_GAP:    w_next = (r_gap != 2'd0) ? RX_GAP : r_term ? DONE : RX_WAIT;
            default:   w_next = IDLE;
        endcase
    end

    // transaction datapath: latches, indices, gap and timeout counters, status flags
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_start_d <= 1'b0;
            r_cmd_len <= '0;
            r_timeout <= '0;
            r_idx     <= '0;
            r_to      <= '0;
            r_gap     <= '0;
            r_byte    <= '0;
            r_w_data  <= '0;
            r_rsp_len <= '0;
            r_e_to    <= 1'b0;
            r_e_of    <= 1'b0;
            r_term    <= 1'b0;
        end else begin
            r_start_d <= i_start;
            if (r_state == IDLE && w_start_edge) begin
                r_cmd_len <= i_cmd_len;
                r_timeout <= i_timeout;
                r_idx     <= '0;
                r_rsp_len <= '0;
                r_e_to    <= 1'b0;
                r_e_of    <= 1'b0;
            end
            if (w_next != r_state)
                r_gap <= (w_next == FLUSH_GAP) ? 2'(RX_GAP_CYC) :
                         (w_next == TX_GAP) ? 2'(TX_GAP_CYC - 1) : 2'(RX_GAP_CYC - 1);
            else if (r_gap != 2'd0)
                r_gap <= r_gap - 2'd1;
            if (r_state == TX_CHK && w_next == TX_PULSE) r_w_data <= w_cmd_rdata;
            if (r_state == TX_PULSE) r_idx <= r_idx + 1'b1;
            if (w_next == RX_WAIT && r_state != RX_WAIT) r_to <= r_timeout;
            else if (r_state == RX_WAIT && r_to != '0) r_to <= r_to - 1'b1;
            if (r_state == RX_WAIT && !i_uart_rx_empty) r_byte <= i_uart_r_data;
            if (r_state == RX_WAIT && w_next == DONE) r_e_to <= 1'b1;
            if (r_state == RX_POP) begin
                r_term <= !w_skip && (r_byte == TERM);
                if (w_rsp_we) r_rsp_len <= r_rsp_len + 1'b1;
                else if (!w_skip) r_e_of <= 1'b1;
            end
        end
endmodule

// File: tb/tb_uart_line_ctl.sv
// tb_uart_line_ctl: randomized transactions against a queue-based uart peer and response model
module tb_uart_line_ctl;
    localparam logic [7:0] TERM = 8'h3E;
    logic        clk = 1'b0, reset = 1'b1;
    logic        start = 1'b0, cmd_wr = 1'b0;
    logic [4:0]  cmd_len = '0;
    logic [3:0]  cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic [23:0] timeout = '0;
    logic [4:0]  rsp_addr = '0;
    logic [7:0]  rsp_rdata, uart_w_data;
    logic [5:0]  rsp_len;
    logic        busy, done_tick, e_timeout, e_rsp_of, uart_wr, uart_rd;
    logic        uart_tx_full = 1'b0, uart_rx_empty = 1'b1;
    logic [7:0]  uart_r_data = '0;

    int n_chk = 0, n_pass = 0;
    int cur_len = 0, wr_low = 99, rd_low = 99;
    bit inject_go = 1'b0;
    logic [7:0] cmd_mem [16];
    logic [7:0] rx_q[$], reply_q[$], sent_q[$], body[$];

    uart_line_ctl dut (
        .clk(clk), .reset(reset), .i_start(start), .i_cmd_len(cmd_len), .i_cmd_wr(cmd_wr),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_timeout(timeout), .i_rsp_addr(rsp_addr),
        .o_rsp_rdata(rsp_rdata), .o_rsp_len(rsp_len), .o_busy(busy), .o_done_tick(done_tick),
        .o_e_timeout(e_timeout), .o_e_rsp_of(e_rsp_of), .o_uart_wr(uart_wr), .o_uart_w_data(uart_w_data),
        .i_uart_tx_full(uart_tx_full), .o_uart_rd(uart_rd), .i_uart_r_data(uart_r_data),
        .i_uart_rx_empty(uart_rx_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // uart peer: captures tx bytes, serves the rx FIFO, checks strobe spacing
    always begin
        @(posedge clk);
        #1;
        if (uart_wr) begin
            chk("wr_gap", wr_low >= 2, 1);
            chk("wr_not_full", uart_tx_full, 0);
            sent_q.push_back(uart_w_data);
            wr_low = 0;
        end else wr_low++;
        if (uart_rd) begin
            chk("rd_gap", rd_low >= 2, 1);
            chk("rd_avail", rx_q.size() > 0, 1);
            if (rx_q.size() > 0) void'(rx_q.pop_front());
            rd_low = 0;
        end else rd_low++;
        if (inject_go && sent_q.size() >= cur_len && reply_q.size() > 0 && $urandom_range(0, 3) != 0)
            rx_q.push_back(reply_q.pop_front());
        uart_rx_empty = (rx_q.size() == 0);
        if (rx_q.size() > 0) uart_r_data = rx_q[0];
        else uart_r_data = 8'h00;
    end

    task automatic rand_cmd();
        for (int i = 0; i < 16; i++) cmd_mem[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic gen_body(input int n, input bit term);
        logic [7:0] b;
        body.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == TERM) b = 8'h3F;
            body.push_back(b);
        end
        if (term) body.push_back(TERM);
    endtask

    task automatic load_and_start(input int len, input int to);
        cur_len = len;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cmd_wr = 1'b1; cmd_addr = 4'(i); cmd_wdata = cmd_mem[i];
            if (i == 15) begin
                start = 1'b1; cmd_len = 5'(len); timeout = 24'(to);
            end
        end
        @(negedge clk);
        cmd_wr = 1'b0; start = 1'b0;
    endtask

    task automatic run_txn(input int len, input int to, input int n_stale, input int full_hold, output int done_k);
        int k, hold_left, extra, n, exp_len;
        bit held, has_term;
        reply_q = body;
`ifdef UART_LINE_ECHO_EN
        for (int i = len - 1; i >= 0; i--) reply_q.push_front(cmd_mem[i]);
`endif
        sent_q.delete(); rx_q.delete(); inject_go = 1'b0;
        for (int i = 0; i < n_stale; i++) rx_q.push_back(8'($urandom_range(0, 255)));
        load_and_start(len, to);
        chk("busy_after_start", busy, 1);
        k = 1; done_k = 0; hold_left = 0; held = 1'b0;
        while (done_k == 0 && k < 6000) begin
            if (k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
            if (k == 4 * n_stale + 6) inject_go = 1'b1;
            if (full_hold > 0 && !held && sent_q.size() == 1) begin
                uart_tx_full = 1'b1; hold_left = full_hold; held = 1'b1;
            end else if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) uart_tx_full = 1'b0;
            end
            @(negedge clk);
            k++;
            if (done_tick) begin
                done_k = k;
                chk("busy_at_done", busy, 0);
            end
        end
        chk("done_seen", done_k != 0, 1);
        inject_go = 1'b0; uart_tx_full = 1'b0; start = 1'b0;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            extra += int'(done_tick);
        end
        chk("done_once", extra, 0);
        chk("idle_busy", busy, 0);
        chk("sent_n", sent_q.size(), len);
        for (int i = 0; i < len && i < sent_q.size(); i++) chk("sent_byte", sent_q[i], cmd_mem[i]);
        n = body.size();
        has_term = (n > 0) && (body[n-1] == TERM);
        exp_len = (n > 32) ? 32 : n;
        chk("rsp_len", rsp_len, exp_len);
        chk("e_timeout", e_timeout, !has_term);
        chk("e_rsp_of", e_rsp_of, n > 32);
        chk("rx_left", rx_q.size() + reply_q.size(), 0);
        for (int i = 0; i < exp_len; i++) begin
            @(negedge clk);
            rsp_addr = 5'(i);
            @(negedge clk);
            chk("rsp_byte", rsp_rdata, body[i]);
        end
    endtask

    initial begin
        int dk, w;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_tick, 0);
        chk("rst_e_timeout", e_timeout, 0);
        chk("rst_e_rsp_of", e_rsp_of, 0);
        chk("rst_uart_wr", uart_wr, 0);
        chk("rst_uart_rd", uart_rd, 0);
        chk("rst_rsp_len", rsp_len, 0);
        chk("rst_w_data", uart_w_data, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        reset = 1'b0;
        @(negedge clk);

        rand_cmd();
        cmd_mem[0] = 8'h41; cmd_mem[1] = 8'h54; cmd_mem[2] = 8'h0D;
        body = '{8'h4F, 8'h4B, 8'h0D, 8'h3E};
        run_txn(3, 200, 0, 0, dk);

        body.delete();
        run_txn(0, 1000, 0, 0, dk);
        chk("timeout_latency", dk, 3 + 1000 + 1);

        rand_cmd(); gen_body(40, 1);
        run_txn($urandom_range(1, 4), 200, 0, 0, dk);

        rand_cmd(); gen_body(5, 1);
        run_txn(6, 200, 0, 500, dk);

        rand_cmd(); gen_body(6, 1);
        run_txn(2, 200, 2, 0, dk);

        body.delete();
        run_txn(0, 0, 0, 0, dk);
        chk("timeout0_latency", dk, 4);

        rand_cmd(); gen_body(10, 1);
        run_txn(16, 200, 0, 0, dk);

        rand_cmd(); body.delete(); reply_q.delete(); sent_q.delete(); rx_q.delete(); inject_go = 1'b0;
        load_and_start(3, 100);
        w = 0;
        while (sent_q.size() == 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("rst_reach_tx", sent_q.size(), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_wr", uart_wr, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_busy", busy, 0);
        chk("postrst_wr", uart_wr, 0);
        chk("postrst_rsp_len", rsp_len, 0);
        rand_cmd(); gen_body(4, 1);
        run_txn(3, 200, 0, 0, dk);

        for (int t = 0; t < 12; t++) begin
            rand_cmd();
            gen_body($urandom_range(0, 36), $urandom_range(0, 3) != 0);
            run_txn($urandom_range(0, 16), $urandom_range(20, 120), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0, dk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_line_ctl.md
Name: uart_line_ctl

Overview:
Host-side line controller that sits on the user end of the uart block.
- Sends a command string held in an internal command buffer by driving the uart write side (wr_uart/w_data). The write strobe is pulsed because the uart edge-triggers it.
- Collects the reply by popping the uart rx FIFO (rd_uart/r_data) into an internal response buffer until the terminator byte arrives or a timeout expires.
- Gives a state machine or CPU one request/response transaction per start pulse.

Parameters:
DBIT, 8, data byte width; must match the uart DBIT.
CMD_AW, 4, command buffer address bits (16 bytes).
RSP_AW, 5, response buffer address bits (32 bytes).
TO_BITS, 24, width of the timeout counter.
TERM, 8'h3E, response terminator byte ('>'); stored in the response buffer.

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  level; a 0->1 edge, sampled only in IDLE, begins a transaction
cmd_len  in  CMD_AW+1  bytes to send, 0..2^CMD_AW; latched on start
cmd_wr  in  1  command buffer write enable (ignored while busy)
cmd_addr  in  CMD_AW  command buffer write address
cmd_wdata  in  DBIT  command buffer write data
timeout  in  TO_BITS  clk cycles allowed between received bytes; latched on start
rsp_addr  in  RSP_AW  response buffer read address
rsp_rdata  out  DBIT  response byte at rsp_addr, registered, 1-cycle latency
rsp_len  out  RSP_AW+1  bytes stored, including TERM
busy  out  1  high from the cycle after the start edge until done_tick
done_tick  out  1  one-cycle pulse at transaction end
e_timeout  out  1  sticky; the last transaction ended by timeout
e_rsp_of  out  1  sticky; response bytes were dropped because the buffer was full
uart_wr  out  1  to uart wr_uart
uart_w_data  out  DBIT  to uart w_data
uart_tx_full  in  1  from uart tx_full
uart_rd  out  1  to uart rd_uart
uart_r_data  in  DBIT  from uart r_data (FIFO head)
uart_rx_empty  in  1  from uart rx_empty

Behaviour:
- Reset values: all outputs 0 (busy, done_tick, e_timeout, e_rsp_of, uart_wr, uart_rd, rsp_len, uart_w_data, rsp_rdata); state IDLE.
- Strobe rule: uart_wr and uart_rd are high for exactly 1 cycle, followed by at least 2 low cycles (GAP state) before the next strobe. This keeps the uart edge detector and FIFO flags settled.
- FSM states: IDLE, FLUSH, FLUSH_GAP, TX_CHK, TX_PULSE, TX_GAP, RX_WAIT, RX_POP, RX_GAP, DONE.
- IDLE:
  - On the start rising edge: latch cmd_len and timeout, clear rsp_len, e_timeout and e_rsp_of, set busy, go to FLUSH.
  - The start edge detector is registered and runs in every state. Edges outside IDLE are discarded.
- FLUSH: while uart_rx_empty=0, pulse uart_rd (via FLUSH_GAP) to discard stale bytes. When empty, go to TX_CHK with tx index = 0.
- TX_CHK:
  - If index == cmd_len, go to RX_WAIT; cmd_len=0 goes straight to receive.
  - Otherwise, if uart_tx_full=0, drive uart_w_data = cmd[index] and go to TX_PULSE.
  - While uart_tx_full=1, stall; no timeout applies during transmit.
- TX_PULSE: uart_wr=1, uart_w_data held stable; index++. Then TX_GAP (2 cycles), then TX_CHK.
- RX_WAIT:
  - The timeout counter loads the latched timeout on entry and after each accepted byte, and decrements each cycle.
  - If uart_rx_empty=0: capture uart_r_data and go to RX_POP.
  - Else if counter == 0: set e_timeout and go to DONE. A latched timeout of 0 times out on the first empty cycle.
- RX_POP:
  - uart_rd=1.
  - If rsp_len < 2^RSP_AW, write the byte at rsp_len and increment rsp_len.
  - Else set e_rsp_of and discard the byte, but still test it against TERM.
  - If byte == TERM, go to DONE after RX_GAP; otherwise go to RX_WAIT after RX_GAP (2 cycles).
- DONE: done_tick=1 for 1 cycle, busy=0, go to IDLE.
- Buffer access:
  - Command buffer: synchronous write port plus internal read port.
  - Response buffer: internal write port plus external registered read port; readable at any time.
  - Simultaneous cmd_wr and start edge in IDLE: the write completes first. The byte is sent only if its address < cmd_len.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Bytes already in the uart FIFOs are not recovered; the next transaction's FLUSH drains stale rx bytes.
- Width rules: rsp_len saturates at 2^RSP_AW; the timeout counter does not wrap.

Optional Feature:
UART_LINE_ECHO_EN
- With the macro: the receive phase first discards exactly cmd_len popped bytes (the device echo). These bytes are not stored, not tested for TERM, and not counted against overflow. They are still subject to the timeout.
- Without the macro: every received byte is stored.

Decomposition:
- Package uart_line_pkg: state encoding, TERM default, TX_GAP/RX_GAP cycle constants (2).
- One sub-module, uart_line_buf: parameterised single-clock dual-port RAM (DBIT x 2^AW) with registered read. It is instantiated twice, once for the command buffer and once for the response buffer.

Test Plan:
- Load "AT\r" (41 54 0D), cmd_len=3; uart loopback returns "OK\r>" -> 3 uart_wr pulses, each followed by ≥2 low cycles; rsp_len=4; rsp bytes 4F 4B 0D 3E; done_tick once; e_timeout=0.
- Peer silent, timeout=1000 -> done_tick exactly 1001 cycles after entering RX_WAIT; e_timeout=1; rsp_len=0.
- 40 bytes without TERM, then 3E, with RSP_AW=5 -> rsp_len=32; e_rsp_of=1; done_tick after 3E.
- Hold uart_tx_full=1 for 500 cycles during send -> no uart_wr pulse while full; all bytes sent afterwards; no timeout.
- Two stale bytes in the rx FIFO before start -> both popped in FLUSH and absent from the response.
- Assert reset during TX_GAP -> next cycle busy=0, uart_wr=0, state IDLE; a new start completes normally.
